imem_burst_ctrl: RTL and testbench

//  Memory-side burst responder for the instruction cache: accepts one block-fill request
//  (byte address + burst length) and streams beats back on mem_data/mem_valid/mem_last.

---
 rtl/synapse_mem_pkg.sv | 16 +
 rtl/imem_burst_ctrl.sv | 114 +++++++++++
 tb/tb_imem_burst_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/synapse_mem_pkg.sv
// Shared memory-subsystem definitions for the instruction fetch path.
package synapse_mem_pkg;

    // Burst controller state encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } state_t;

    // Width of a "beats minus one" burst length field; the icache uses the same rule
    function automatic int burst_len_width(input int max_burst);
        return $clog2(max_burst) + 1;
    endfunction

endpackage

// File: rtl/imem_burst_ctrl.sv
// Memory-side burst responder: accepts one block-fill request, waits a
// programmable latency, then streams gap-free beats read from a synchronous ROM.
module imem_burst_ctrl
    import synapse_mem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_BURST      = 8,
    parameter int LATENCY        = 2,
    parameter int ROM_ADDR_WIDTH = 10
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  mem_req,
    input  logic [ADDR_WIDTH-1:0]                 mem_addr,
    input  logic [burst_len_width(MAX_BURST)-1:0] mem_burst_len,
    output logic                                  mem_ready,
    output logic [DATA_WIDTH-1:0]                 mem_data,
    output logic                                  mem_valid,
    output logic                                  mem_last,
    output logic                                  rom_en,
    output logic [ROM_ADDR_WIDTH-1:0]             rom_addr,
    input  logic [DATA_WIDTH-1:0]                 rom_rdata,
    output logic                                  req_overrun
);

    localparam int OFF_W  = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W  = $clog2(MAX_BURST);
    localparam int LEN_W  = burst_len_width(MAX_BURST);
    localparam int WAIT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    localparam logic [IDX_W-1:0]  MAX_IDX  = IDX_W'(MAX_BURST - 1);
    localparam logic [LEN_W-1:0]  MAX_LEN  = LEN_W'(MAX_BURST - 1);
    localparam logic [WAIT_W-1:0] LAT_LOAD = WAIT_W'(LATENCY);

    state_t                    state;
    state_t                    state_next;
    logic [ROM_ADDR_WIDTH-1:0] base;
    logic [IDX_W-1:0]          last_idx;
    logic [IDX_W-1:0]          beat_idx;
    logic [WAIT_W-1:0]         wait_cnt;
    logic [IDX_W-1:0]          len_clamped;
    logic                      accept;
    logic                      issue_last;

    // Byte-offset bits and address bits above the ROM are intentionally dropped
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr[ADDR_WIDTH-1:OFF_W+ROM_ADDR_WIDTH], mem_addr[OFF_W-1:0]};

    assign mem_ready   = (state == IDLE);
    assign mem_data    = rom_rdata;
    assign len_clamped = (mem_burst_len > MAX_LEN) ? MAX_IDX : mem_burst_len[IDX_W-1:0];

    // Next-state decode plus ROM issue strobes; the final issue marks the burst end
    always_comb begin
        state_next = state;
        accept     = mem_req && (state == IDLE);
        rom_en     = 1'b0;
        rom_addr   = '0;
        issue_last = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 0) state_next = BURST;
                    else              state_next = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == WAIT_W'(1)) state_next = BURST;
            end
            BURST: begin
                rom_en   = 1'b1;
                rom_addr = base + ROM_ADDR_WIDTH'(beat_idx);
                if (beat_idx == last_idx) begin
                    issue_last = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Request latch, latency/beat counters, beat strobes and sticky overrun flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base        <= '0;
            last_idx    <= '0;
            beat_idx    <= '0;
            wait_cnt    <= '0;
            mem_valid   <= 1'b0;
            mem_last    <= 1'b0;
            req_overrun <= 1'b0;
        end else begin
            if (accept) begin
                base     <= mem_addr[OFF_W +: ROM_ADDR_WIDTH];
                last_idx <= len_clamped;
                beat_idx <= '0;
                wait_cnt <= LAT_LOAD;
            end
            if (state == WAIT) wait_cnt <= wait_cnt - WAIT_W'(1);
            if (state == BURST) beat_idx <= issue_last ? '0 : beat_idx + IDX_W'(1);
            mem_valid <= rom_en;
            mem_last  <= issue_last;
            if (mem_req && !mem_ready) req_overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_imem_burst_ctrl.sv
// Self-checking bench for imem_burst_ctrl: one instance with LATENCY=2 and one
// with LATENCY=0, each reading a behavioural 1-cycle synchronous ROM.
module tb_imem_burst_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        drive_req = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [3:0]  mem_burst_len = '0;

    logic        req_a, ready_a, valid_a, last_a, en_a, ovr_a;
    logic        req_b, ready_b, valid_b, last_b, en_b, ovr_b;
    logic [31:0] data_a, data_b, rdata_a, rdata_b;
    logic [9:0]  addr_a, addr_b;

    logic        s_ready, s_valid, s_last, s_en, s_ovr;
    logic [31:0] s_data;
    logic [9:0]  s_addr;

    logic [31:0] rom [1024];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        s;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [9:0]  base;
        int          beats;
    } vec_t;

    vec_t vecs [7];

    // Clock generation
    always #5 clk = ~clk;

    assign req_a = drive_req & ~sel;
    assign req_b = drive_req & sel;

    assign s_ready = sel ? ready_b : ready_a;
    assign s_valid = sel ? valid_b : valid_a;
    assign s_last  = sel ? last_b  : last_a;
    assign s_en    = sel ? en_b    : en_a;
    assign s_ovr   = sel ? ovr_b   : ovr_a;
    assign s_data  = sel ? data_b  : data_a;
    assign s_addr  = sel ? addr_b  : addr_a;

    imem_burst_ctrl #(.LATENCY(2)) dut_a (
        .clk(clk), .rst(rst), .mem_req(req_a), .mem_addr(mem_addr),
        .mem_burst_len(mem_burst_len), .mem_ready(ready_a), .mem_data(data_a),
        .mem_valid(valid_a), .mem_last(last_a), .rom_en(en_a), .rom_addr(addr_a),
        .rom_rdata(rdata_a), .req_overrun(ovr_a)
    );

    imem_burst_ctrl #(.LATENCY(0)) dut_b (
        .clk(clk), .rst(rst), .mem_req(req_b), .mem_addr(mem_addr),
        .mem_burst_len(mem_burst_len), .mem_ready(ready_b), .mem_data(data_b),
        .mem_valid(valid_b), .mem_last(last_b), .rom_en(en_b), .rom_addr(addr_b),
        .rom_rdata(rdata_b), .req_overrun(ovr_b)
    );

    // Behavioural synchronous ROMs, one read port per controller
    always @(posedge clk) begin
        if (en_a) rdata_a <= rom[addr_a];
        if (en_b) rdata_b <= rom[addr_b];
    end

    function automatic logic [31:0] rom_val(input logic [9:0] a);
        return 32'hA500_0000 ^ ({22'd0, a} * 32'd257);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Issue one request in the current cycle and check every cycle up to its last beat.
    // Returns at the sampling point of the last-beat cycle so a caller may chain a request.
    task automatic applyStimulus(input logic s, input logic [31:0] addr, input logic [3:0] len,
                                 input logic [9:0] base, input int beats, input int pulse_k);
        int lat;
        int last_k;
        logic [9:0] ea;
        lat           = s ? 0 : 2;
        last_k        = lat + 1 + beats;
        sel           = s;
        mem_addr      = addr;
        mem_burst_len = len;
        drive_req     = 1'b1;
        #1;
        checkOutput("ready_at_req", {31'd0, s_ready}, 32'd1);
        for (int k = 1; k <= last_k; k++) begin
            @(negedge clk);
            checkOutput("valid", {31'd0, s_valid}, {31'd0, (k >= lat + 2)});
            checkOutput("last",  {31'd0, s_last},  {31'd0, (k == last_k)});
            checkOutput("ready", {31'd0, s_ready}, {31'd0, (k == last_k)});
            checkOutput("rom_en", {31'd0, s_en},   {31'd0, (k >= lat + 1 && k <= lat + beats)});
            if (k >= lat + 1 && k <= lat + beats) begin
                ea = base + 10'(k - lat - 1);
                checkOutput("rom_addr", {22'd0, s_addr}, {22'd0, ea});
            end
            if (k >= lat + 2) begin
                ea = base + 10'(k - lat - 2);
                checkOutput("data", s_data, rom_val(ea));
            end
            drive_req = (k == pulse_k);
            if (k == pulse_k) begin
                mem_addr      = 32'hDEAD_0000;
                mem_burst_len = 4'd1;
            end
        end
        drive_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = rom_val(10'(i));

        vecs[0] = '{1'b0, 32'h0000_0040, 4'd7,  10'h010, 8};
        vecs[1] = '{1'b1, 32'h0000_001C, 4'd0,  10'h007, 1};
        vecs[2] = '{1'b0, 32'h0000_0FF8, 4'd3,  10'h3FE, 4};
        vecs[3] = '{1'b0, 32'h0000_0103, 4'd2,  10'h040, 3};
        vecs[4] = '{1'b0, 32'h0000_0020, 4'd15, 10'h008, 8};
        vecs[5] = '{1'b1, 32'h1000_0404, 4'd9,  10'h101, 8};
        vecs[6] = '{1'b0, 32'h0000_0010, 4'd1,  10'h004, 2};

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_valid", {31'd0, valid_a}, 32'd0);
        checkOutput("rst_last",  {31'd0, last_a},  32'd0);
        checkOutput("rst_en",    {31'd0, en_a},    32'd0);
        checkOutput("rst_addr",  {22'd0, addr_a},  32'd0);
        checkOutput("rst_ready", {31'd0, ready_a}, 32'd1);
        checkOutput("rst_ovr",   {31'd0, ovr_a},   32'd0);
        checkOutput("rst_ready_b", {31'd0, ready_b}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven single bursts
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].s, vecs[i].addr, vecs[i].len, vecs[i].base, vecs[i].beats, 0);
            @(negedge clk);
        end

        // Back-to-back: second request in the cycle of the first burst's last beat
        applyStimulus(1'b0, 32'h0000_0040, 4'd7, 10'h010, 8, 0);
        applyStimulus(1'b0, 32'h0000_0080, 4'd7, 10'h020, 8, 0);
        @(negedge clk);
        checkOutput("b2b_ovr", {31'd0, ovr_a}, 32'd0);

        // Request pulse during beat 3 is ignored but sets the sticky overrun flag
        applyStimulus(1'b0, 32'h0000_0040, 4'd7, 10'h010, 8, 6);
        @(negedge clk);
        checkOutput("ovr_set", {31'd0, ovr_a}, 32'd1);
        applyStimulus(1'b0, 32'h0000_0010, 4'd1, 10'h004, 2, 0);
        @(negedge clk);
        checkOutput("ovr_sticky", {31'd0, ovr_a}, 32'd1);

        // Reset after beat 2 of an 8-beat burst
        sel = 1'b0;
        mem_addr = 32'h0000_0040;
        mem_burst_len = 4'd7;
        drive_req = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            drive_req = 1'b0;
        end
        checkOutput("pre_rst_valid", {31'd0, valid_a}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_valid", {31'd0, valid_a}, 32'd0);
        checkOutput("mid_rst_last",  {31'd0, last_a},  32'd0);
        checkOutput("mid_rst_en",    {31'd0, en_a},    32'd0);
        checkOutput("mid_rst_ovr",   {31'd0, ovr_a},   32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checkOutput("post_rst_valid", {31'd0, valid_a}, 32'd0);
            checkOutput("post_rst_ready", {31'd0, ready_a}, 32'd1);
        end
        applyStimulus(1'b0, 32'h0000_0040, 4'd15, 10'h010, 8, 0);
        @(negedge clk);
        checkOutput("final_ovr", {31'd0, ovr_a}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
